char_buffer: RTL and testbench
==============================

Name: char_buffer

Overview:
- Sink end of the character-write interface (char_x / char_y / char_chr / char_str) driven by the core.
- Holds an 80x30 screen of 9-bit character codes in block RAM.
- Serves a 1-cycle-latency read port for the text-mode scanout.
- Provides a hardware clear-screen sweep; writes arriving during a clear are buffered in a small FIFO and applied afterwards.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- CHR_W, 9, character code width.
- FILL_CHR, 9'h020, code written by a clear sweep.
- FIFO_DEPTH, 4, pending-write entries held during clear/drain (power of two).
- CLEAR_ON_RESET, 1, start a clear sweep when reset_n deasserts.

Ports:
- clk_sys  in  1  125 MHz system clock.
- reset_n  in  1  synchronous reset, active-low.
- char_x  in  7  write column.
- char_y  in  6  write row.
- char_chr  in  CHR_W  write character.
- char_str  in  1  write strobe, one write per high cycle.
- clear_req  in  1  single-cycle pulse: start a clear sweep.
- busy  out  1  high in CLEAR or DRAIN.
- wr_drop  out  1  one-cycle pulse when a write is discarded (FIFO full).
- rd_x  in  7  scanout column.
- rd_y  in  6  scanout row.
- rd_chr  out  CHR_W  character at (rd_x, rd_y) sampled the previous cycle.

Behaviour:
- Interface fixed: one clock, clk_sys. Reset reset_n is synchronous and active-low.
- Reset values while reset_n=0: busy=0, wr_drop=0, rd_chr=0, FIFO empty, state IDLE.
  - RAM contents are not reset.
  - First cycle after deassert: state=CLEAR if CLEAR_ON_RESET, else IDLE.
- Address = y*COLS+x, computed as (y<<6)+(y<<4)+x for COLS=80; 12-bit.
- Writes with x>=COLS or y>=ROWS are ignored silently; no drop pulse.
- Reads with out-of-range coordinates return FILL_CHR next cycle.
- Read port:
  - Registered, latency 1.
  - Read-during-write to the same address returns the old data.
  - Reads are never stalled, including during CLEAR.
- FSM states:
  - IDLE: with FIFO empty, a valid char_str writes RAM that same edge.
  - CLEAR: clr_addr sweeps 0..COLS*ROWS-1, writing FILL_CHR one address per cycle (2400 cycles). Incoming writes push into the FIFO. After the last address: DRAIN if the FIFO is non-empty, else IDLE.
  - DRAIN: pop and write one entry per cycle. A simultaneous push and pop is allowed, so occupancy is unchanged. Go to IDLE on the cycle the last entry is popped with no push that cycle.
- FIFO full and a write arrives (CLEAR or DRAIN, no pop that cycle): write discarded, wr_drop=1 for that cycle.
- clear_req in any state:
  - FIFO is flushed, because its entries predate the clear.
  - clr_addr restarts at 0 and state goes to CLEAR.
  - A char_str in the same cycle as clear_req counts as after the clear and is pushed to the empty FIFO.
- busy is 1 in CLEAR and DRAIN, 0 in IDLE. It is registered with the state.
- Write ordering is preserved: FIFO entries apply in arrival order, and no direct write bypasses a non-empty FIFO.

Optional Feature:
- Macro: CHAR_BUFFER_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count (16 bits), incremented on every wr_drop and saturating at 16'hFFFF.
  - Cleared by reset_n only; clear_req does not clear it.
  - Adds input drop_clr (1 bit), which zeroes drop_count. drop_clr wins over a simultaneous increment.
- Undefined: neither port exists, and wr_drop is the only drop indication.

Decomposition:
- Package char_buffer_pkg holds:
  - COLS/ROWS defaults and SCREEN_CELLS=COLS*ROWS.
  - The state enum typedef {IDLE, CLEAR, DRAIN}.
  - The write-request struct {x, y, chr}.
- One sub-module, char_wr_fifo: synchronous FIFO of write-request structs.
  - Ports: push, pop, full, empty, flush.
  - Handles simultaneous push/pop.
- RAM instantiated through the existing bram_sdp block with both clocks tied to clk_sys.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy high exactly 2400 cycles; afterwards read (0,0), (79,29), (40,15) each return 9'h020.
- IDLE, write (5,2)=9'h041, then read (5,2) next cycle -> rd_chr=9'h041 one cycle after the read address; write (80,2) or (3,30) -> RAM unchanged, wr_drop=0.
- clear_req, then 3 writes at cycles 10-12 of the sweep -> after 2400 cycles, DRAIN for 3 cycles; all 3 cells hold the written codes and all other cells hold 9'h020.
- During CLEAR, 6 consecutive writes with FIFO_DEPTH=4 -> first 4 retained, wr_drop pulses on writes 5 and 6, then busy falls 4 cycles after the sweep ends.
- In DRAIN with 2 entries queued, write one per cycle -> occupancy stays at 2 until writes stop; order preserved, last write to a repeated address wins.
- clear_req mid-DRAIN together with char_str (1,1)=9'h058 -> FIFO flushed, sweep restarts at 0, (1,1)=9'h058 after completion; reset_n low mid-sweep -> busy=0 next cycle.

Source files
------------

// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg: shared constants, FSM state type and write-request type for
// the character buffer and its pending-write FIFO.
package char_buffer_pkg;

    localparam int COLS_DEF     = 80;
    localparam int ROWS_DEF     = 30;
    localparam int SCREEN_CELLS = COLS_DEF * ROWS_DEF;
    localparam int CHR_W_DEF    = 9;
    localparam int ADDR_W       = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [6:0]           x;
        logic [5:0]           y;
        logic [CHR_W_DEF-1:0] chr;
    } wr_req_t;

    // y*80 + x built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [5:0] y);
        return {y, 6'b0} + {2'b0, y, 4'b0} + {5'b0, x};
    endfunction

endpackage

// File: rtl/char_buffer_if.sv
// char_buffer_if: character-write bus from the core (master) into char_buffer (slave).
interface char_buffer_if #(
    parameter int CHR_W = 9
);
    logic [6:0]       char_x;
    logic [5:0]       char_y;
    logic [CHR_W-1:0] char_chr;
    logic             char_str;

    // char_str is a valid with no ready: the sink takes every strobe and either
    // writes it, queues it, ignores it (off-screen) or reports it on wr_drop.
    modport master (output char_x, char_y, char_chr, char_str);
    modport slave  (input  char_x, char_y, char_chr, char_str);
endinterface

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port block RAM, one write port, one registered read port
// (read-during-write to the same address returns the old data).
module bram_sdp #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 9,
    parameter int DEPTH  = 2400
) (
    input  logic              clk_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              clk_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_a) begin
        if (we_a) mem[addr_a] <= din_a;
    end

    always_ff @(posedge clk_b) begin
        dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/char_wr_fifo.sv
// char_wr_fifo: small synchronous FIFO of write requests; flush empties it and a
// push in the same cycle lands in the freshly emptied FIFO.
module char_wr_fifo
    import char_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    flush,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t pop_data,
    output logic    full,
    output logic    empty,
    output logic [AW:0] count
);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    wr_req_t       mem [DEPTH];
    logic          do_push, do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when an entry leaves the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_ONE : '0;
            count  <= push ? CNT_ONE : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            if (push) mem[0] <= push_data;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/char_buffer.sv
// char_buffer: 80x30 text screen store with clear-screen sweep and pending-write FIFO.
// Optional: define CHAR_BUFFER_DROP_COUNT_EN for the drop_count / drop_clr ports.
module char_buffer
    import char_buffer_pkg::*;
#(
    parameter int               COLS           = COLS_DEF,
    parameter int               ROWS           = ROWS_DEF,
    parameter int               CHR_W          = CHR_W_DEF,
    parameter logic [CHR_W-1:0] FILL_CHR       = 9'h020,
    parameter int               FIFO_DEPTH     = 4,
    parameter int               CLEAR_ON_RESET = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    char_buffer_if.slave     wr_bus,
    input  logic             clear_req,
    output logic             busy,
    output logic             wr_drop,
    input  logic [6:0]       rd_x,
    input  logic [5:0]       rd_y,
    output logic [CHR_W-1:0] rd_chr,
    output buf_state_t       dbg_state
`ifdef CHAR_BUFFER_DROP_COUNT_EN
    ,
    input  logic             drop_clr,
    output logic [15:0]      drop_count
`endif
);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [6:0]        COLS_L    = 7'(COLS);
    localparam logic [5:0]        ROWS_L    = 6'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    buf_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              init_q, start_clr, wr_valid, drop;
    wr_req_t           in_req, head;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CHR_W-1:0]  ram_din, ram_dout;
    logic              rd_live_q, rd_oob_q;

    assign in_req    = '{x: wr_bus.char_x, y: wr_bus.char_y, chr: wr_bus.char_chr};
    assign wr_valid  = wr_bus.char_str && (wr_bus.char_x < COLS_L) && (wr_bus.char_y < ROWS_L);
    // The first cycle out of reset behaves like a clear_req pulse when CLEAR_ON_RESET is set
    assign start_clr = clear_req || init_q;
    assign dbg_state = state;

    always_comb begin
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        drop       = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = cell_addr(in_req.x, in_req.y);
        ram_din    = in_req.chr;
        if (start_clr) begin
            // Queued entries predate the clear; a coincident write belongs after it
            fifo_flush = 1'b1;
            fifo_push  = wr_valid;
        end else begin
            case (state)
                IDLE: ram_we = wr_valid;
                CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_addr;
                    ram_din   = FILL_CHR;
                    fifo_push = wr_valid && !fifo_full;
                    drop      = wr_valid && fifo_full;
                end
                DRAIN: begin
                    fifo_pop  = !fifo_empty;
                    ram_we    = !fifo_empty;
                    ram_addr  = cell_addr(head.x, head.y);
                    ram_din   = head.chr;
                    fifo_push = wr_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
            wr_drop  <= 1'b0;
            init_q   <= (CLEAR_ON_RESET != 0);
        end else begin
            init_q  <= 1'b0;
            wr_drop <= drop;
            if (start_clr) begin
                state    <= CLEAR;
                clr_addr <= '0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    CLEAR: begin
                        if (clr_addr == LAST_ADDR) begin
                            if (!fifo_empty || fifo_push) begin
                                state <= DRAIN;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            clr_addr <= clr_addr + ADDR_ONE;
                        end
                    end
                    DRAIN: begin
                        if (fifo_count == CNT_ONE && !fifo_push) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rd_live_q <= 1'b0;
            rd_oob_q  <= 1'b0;
        end else begin
            rd_live_q <= 1'b1;
            rd_oob_q  <= (rd_x >= COLS_L) || (rd_y >= ROWS_L);
        end
    end

    assign rd_chr = !rd_live_q ? '0 : (rd_oob_q ? FILL_CHR : ram_dout);

`ifdef CHAR_BUFFER_DROP_COUNT_EN
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (wr_drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    char_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_sys),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (in_req),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    bram_sdp #(.ADDR_W(ADDR_W), .DATA_W(CHR_W), .DEPTH(COLS * ROWS)) u_ram (
        .clk_a  (clk_sys),
        .we_a   (ram_we),
        .addr_a (ram_addr),
        .din_a  (ram_din),
        .clk_b  (clk_sys),
        .addr_b (cell_addr(rd_x, rd_y)),
        .dout_b (ram_dout)
    );
endmodule

// File: tb/tb_char_buffer.sv
// tb_char_buffer: randomized scoreboard bench for char_buffer against a screen-array
// reference model (clear = fill then apply accepted writes in arrival order).
`timescale 1ns/1ps
module tb_char_buffer;
    import char_buffer_pkg::*;

    localparam logic [8:0] FILL  = 9'h020;
    localparam int         CELLS = 80 * 30;
    localparam int         SWEEP = 2400;
    localparam int         DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk_sys   = 1'b0;
    logic reset_n   = 1'b0;
    logic clear_req = 1'b0;
    logic [6:0] rd_x = '0;
    logic [5:0] rd_y = '0;
    logic       busy, wr_drop;
    logic [8:0] rd_chr;
    buf_state_t dbg_state;
`ifdef CHAR_BUFFER_DROP_COUNT_EN
    logic        drop_clr = 1'b0;
    logic [15:0] drop_count;
`endif

    always #4 clk_sys = ~clk_sys;

    char_buffer_if #(.CHR_W(9)) wr_bus ();

    char_buffer dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .wr_bus    (wr_bus),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_drop   (wr_drop),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_chr    (rd_chr),
        .dbg_state (dbg_state)
`ifdef CHAR_BUFFER_DROP_COUNT_EN
        ,
        .drop_clr   (drop_clr),
        .drop_count (drop_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int         tests = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         exp_cell_q[$];
    logic       rd_act = 1'b0;
    logic       rd_seen = 1'b0;
    int         busy_cnt = 0, drain_cnt = 0, drop_pulses = 0, exp_drops = 0;
    logic [8:0] mon_exp;
    int         mon_cell;

    // reference model: screen image plus the writes accepted while busy
    logic [8:0] scr [CELLS];
    int         pend_cell[$];
    logic [8:0] pend_chr[$];

    // ---------------- monitor ----------------
    always @(posedge clk_sys) rd_seen <= rd_act;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (busy === 1'b1)    busy_cnt++;
            if (wr_drop === 1'b1) drop_pulses++;
            if (dbg_state == DRAIN) drain_cnt++;
        end
        if (rd_seen) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_chr: read seen with no expected entry, got %h", rd_chr);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_cell = exp_cell_q.pop_front();
                if (rd_chr !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_chr (x=%0d,y=%0d): got %h expected %h",
                             mon_cell / 256, mon_cell % 256, rd_chr, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_wr(input int x, input int y, input logic [8:0] c);
        wr_bus.char_x   = 7'(x);
        wr_bus.char_y   = 6'(y);
        wr_bus.char_chr = c;
        wr_bus.char_str = 1'b1;
    endtask

    task automatic clr_wr();
        wr_bus.char_str = 1'b0;
    endtask

    function automatic logic [8:0] model_rd(input int x, input int y);
        if (x >= 80 || y >= 30) return FILL;
        return scr[y * 80 + x];
    endfunction

    task automatic queue_read(input int x, input int y);
        rd_x = 7'(x);
        rd_y = 6'(y);
        exp_q.push_back(model_rd(x, y));
        exp_cell_q.push_back(x * 256 + y);
        rd_act = 1'b1;
    endtask

    task automatic issue_read(input int x, input int y);
        queue_read(x, y);
        tick();
        rd_act = 1'b0;
    endtask

    task automatic direct_write(input int x, input int y, input logic [8:0] c);
        set_wr(x, y, c);
        if (x < 80 && y < 30) scr[y * 80 + x] = c;
        tick();
        clr_wr();
    endtask

    task automatic verify_all();
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 80; x++)
                issue_read(x, y);
        tick();
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, " idle_timeout"}, (busy === 1'b0) ? 0 : 1, 0);
    endtask

    task automatic model_clear_start();
        pend_cell.delete();
        pend_chr.delete();
    endtask

    // in_sweep: nothing leaves the FIFO yet, so only DEPTH writes fit
    task automatic model_busy_write(input int x, input int y, input logic [8:0] c, input bit in_sweep);
        if (x >= 80 || y >= 30) return;
        if (in_sweep && pend_cell.size() >= DEPTH) begin
            exp_drops++;
            return;
        end
        pend_cell.push_back(y * 80 + x);
        pend_chr.push_back(c);
    endtask

    task automatic model_clear_end();
        for (int i = 0; i < CELLS; i++) scr[i] = FILL;
        for (int k = 0; k < pend_cell.size(); k++) scr[pend_cell[k]] = pend_chr[k];
    endtask

    task automatic pick(input bit narrow, output int x, output int y, output logic [8:0] c);
        if (narrow) begin
            x = $urandom_range(0, 2);
            y = 0;
        end else begin
            x = $urandom_range(0, 79);
            y = $urandom_range(0, 29);
        end
        c = 9'($urandom_range(0, 511));
    endtask

    // clear_req, n_sw writes from sweep cycle 10, then n_dr writes from the first DRAIN cycle
    task automatic clear_session(input int n_sw, input int n_dr, input bit narrow, input string tag);
        int t, x, y;
        logic [8:0] c;
        busy_cnt  = 0;
        drain_cnt = 0;
        model_clear_start();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        t = 0;
        while (t < 9) begin tick(); t++; end
        for (int i = 0; i < n_sw; i++) begin
            pick(narrow, x, y, c);
            set_wr(x, y, c);
            model_busy_write(x, y, c, 1'b1);
            tick();
            t++;
        end
        clr_wr();
        while (t < SWEEP) begin tick(); t++; end
        for (int i = 0; i < n_dr; i++) begin
            pick(narrow, x, y, c);
            set_wr(x, y, c);
            model_busy_write(x, y, c, 1'b0);
            tick();
        end
        clr_wr();
        wait_idle(tag);
        model_clear_end();
        check({tag, " busy_cycles"}, busy_cnt, SWEEP + pend_cell.size());
        check({tag, " drain_cycles"}, drain_cnt, pend_cell.size());
        check({tag, " drop_pulses"}, drop_pulses, exp_drops);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x, y, t;
        logic [8:0] c;
        wr_bus.char_x   = '0;
        wr_bus.char_y   = '0;
        wr_bus.char_chr = '0;
        wr_bus.char_str = 1'b0;

        // reset and power-up clear
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset wr_drop", wr_drop, 0);
        check("reset rd_chr", rd_chr, 0);
        check("reset state", int'(dbg_state), int'(IDLE));
        reset_n  = 1'b1;
        busy_cnt = 0;
        tick();
        check("busy after reset", busy, 1);
        wait_idle("reset_clear");
        check("reset_clear busy_cycles", busy_cnt, SWEEP);
        model_clear_start();
        model_clear_end();
        issue_read(0, 0);
        issue_read(79, 29);
        issue_read(40, 15);

        // idle writes, ignored writes, out-of-range reads, read-during-write
        direct_write(5, 2, 9'h041);
        issue_read(5, 2);
        direct_write(80, 2, 9'h1FF);
        direct_write(3, 30, 9'h1FF);
        issue_read(0, 3);
        issue_read(80, 2);
        issue_read(3, 30);
        issue_read(127, 63);
        issue_read(5, 2);
        set_wr(5, 2, 9'h155);
        queue_read(5, 2);
        scr[2 * 80 + 5] = 9'h155;
        tick();
        rd_act = 1'b0;
        clr_wr();
        issue_read(5, 2);
        check("idle drop_pulses", drop_pulses, 0);
        check("idle busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            pick(1'b0, x, y, c);
            direct_write(x, y, c);
            issue_read(x, y);
        end

        // clear with 3 queued writes, full check of the screen
        clear_session(3, 0, 1'b0, "clear3");
        verify_all();

        // overflow: 6 writes into a 4-deep FIFO
        clear_session(6, 0, 1'b0, "overflow");
        for (int k = 0; k < pend_cell.size(); k++) issue_read(pend_cell[k] % 80, pend_cell[k] / 80);
        issue_read(0, 0);

        // writes during DRAIN to a small region: occupancy held, last write wins
        clear_session(2, 5, 1'b1, "drain_wr");
        for (int xi = 0; xi < 3; xi++) issue_read(xi, 0);
        issue_read(3, 0);

        // clear_req mid-DRAIN with a coincident write
        model_clear_start();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        t = 0;
        while (t < 9) begin tick(); t++; end
        for (int i = 0; i < 3; i++) begin
            pick(1'b0, x, y, c);
            set_wr(x, y, c);
            tick();
            t++;
        end
        clr_wr();
        while (t < SWEEP + 1) begin tick(); t++; end
        check("mid_drain state", int'(dbg_state), int'(DRAIN));
        model_clear_start();
        clear_req = 1'b1;
        set_wr(1, 1, 9'h058);
        model_busy_write(1, 1, 9'h058, 1'b1);
        tick();
        clear_req = 1'b0;
        clr_wr();
        busy_cnt  = 0;
        drain_cnt = 0;
        check("restart state", int'(dbg_state), int'(CLEAR));
        wait_idle("restart");
        model_clear_end();
        check("restart busy_cycles", busy_cnt, SWEEP + 1);
        check("restart drain_cycles", drain_cnt, 1);
        verify_all();

        // reset mid-sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        check("midsweep reset busy", busy, 0);
        check("midsweep reset state", int'(dbg_state), int'(IDLE));
        check("midsweep reset rd_chr", rd_chr, 0);
        reset_n  = 1'b1;
        busy_cnt = 0;
        tick();
        wait_idle("reset_clear2");
        check("reset_clear2 busy_cycles", busy_cnt, SWEEP);
        model_clear_start();
        model_clear_end();
        issue_read(1, 1);
        issue_read(5, 2);

        // randomized sessions
        for (int s = 0; s < 2; s++) begin
            clear_session($urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
            for (int i = 0; i < 30; i++) begin
                pick(1'b0, x, y, c);
                if ($urandom_range(0, 1) == 1) direct_write(x, y, c);
                issue_read(x, y);
            end
        end
        verify_all();

        tick();
        tick();
        check("exp_q empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
